counter_bound_loader: RTL and testbench
=======================================

Name: counter_bound_loader

Overview:
- Upstream configuration stage for the bounded up-counter.
- Accepts new lower/upper bound pairs over a valid/ready handshake and holds them in a shadow register.
- Commits them to the registered bound outputs that drive the counter only at a wrap point, so the bounds never change mid-sequence.
- Watches the counter's count value to detect the wrap point.

Parameters:
- DATA_WIDTH, 32, width of bounds and count value.
- DEFAULT_LOWER_BOUND, 0, lower_bound value after reset.
- DEFAULT_UPPER_BOUND, 255, upper_bound value after reset.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  a new bound pair is offered.
- cfg_ready  output  1  the loader can accept a pair.
- cfg_lower  input  DATA_WIDTH  offered lower bound.
- cfg_upper  input  DATA_WIDTH  offered upper bound.
- cnt_value  input  DATA_WIDTH  count value fed back from the counter output.
- clear_err  input  1  clears the sticky error flag.
- lower_bound  output  DATA_WIDTH  active lower bound; drives the counter.
- upper_bound  output  DATA_WIDTH  active upper bound; drives the counter.
- pending  output  1  a shadow pair is waiting to commit.
- commit_pulse  output  1  one-cycle strobe in the cycle after a commit.
- cfg_err  output  1  sticky flag: a pair was rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - lower_bound=DEFAULT_LOWER_BOUND, upper_bound=DEFAULT_UPPER_BOUND.
  - State IDLE; shadow registers cleared.
  - pending=0, commit_pulse=0, cfg_err=0, cfg_ready=1.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- States: IDLE, PENDING.
- IDLE:
  - cfg_ready=1.
  - A transfer occurs when cfg_valid and cfg_ready are both high at a clock edge.
  - Accepted pair: stored to the shadow registers; next state PENDING; pending=1 from the next cycle.
  - Rejected pair (cfg_lower > cfg_upper): shadow untouched; cfg_err set; stay IDLE.
  - cfg_lower == cfg_upper is legal (the counter holds that value).
- PENDING:
  - cfg_ready=0; cfg_valid is ignored.
  - Commit condition is evaluated every cycle against the active bounds: cnt_value == upper_bound, OR cnt_value < lower_bound, OR cnt_value > upper_bound.
  - On commit: lower_bound/upper_bound take the shadow values at that edge; commit_pulse=1 for exactly one cycle; pending=0; next state IDLE.
  - Commit latency is one edge after the condition is seen.
- Counter interaction at commit:
  - On the commit edge the counter reloads the old lower_bound.
  - If that value is outside the new range, the counter self-corrects to the new lower_bound on the following edge.
  - This one-cycle transient is accepted behaviour.
- Back-to-back: a new pair can be accepted in the first IDLE cycle after a commit. Minimum spacing is 2 cycles per pair.
- cfg_err:
  - Set on a rejected transfer; cleared by clear_err.
  - Simultaneous set and clear: set wins.
- Reset asserted while PENDING discards the shadow pair; the defaults are restored.
- Comparisons are unsigned at DATA_WIDTH; no arithmetic is performed.

Optional Feature:
- Macro: COUNTER_BOUND_CHECK_EN.
- Defined: the lower > upper check is active, and cfg_err and clear_err behave as above.
- Undefined: every handshake transfer is accepted; cfg_err is tied 0 and clear_err is unused. An inverted pair commits as-is, and the counter then continually reloads lower_bound.

Decomposition:
- Shared package counter_pkg holds:
  - loader_state_t enum {IDLE, PENDING};
  - default bound constants reused by the counter and its testbenches.
- No sub-module. The compare/validate logic is small enough to stay inline in counter_bound_loader.

Test Plan:
- Reset, then hold 4 cycles -> lower_bound=0, upper_bound=255, cfg_ready=1, pending=0, cfg_err=0.
- Offer (10,20) while cnt_value=100 -> pending=1 next cycle, bounds unchanged. Drive cnt_value=255 -> next edge: bounds=(10,20), commit_pulse high for 1 cycle, cfg_ready=1.
- Offer (30,5), macro defined -> transfer consumed, cfg_err=1, state IDLE, bounds unchanged. Assert clear_err and a new bad pair in the same cycle -> cfg_err stays 1.
- In PENDING with shadow (10,20) and active (0,255), drive cnt_value=300 (out of range) -> commit on the next edge.
- Assert rst_n low mid-PENDING, asynchronously between edges -> outputs return to defaults immediately; the shadow pair is never committed.
- Instantiate with the counter: load (5,7) -> counter sequence after wrap is ..255,0,5,6,7,5; the single transient 0 is accepted.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared loader state encoding and default bounds for the bounded up-counter family.
package counter_pkg;
    localparam int CNT_DATA_WIDTH    = 32;
    localparam int CNT_DEFAULT_LOWER = 0;
    localparam int CNT_DEFAULT_UPPER = 255;
    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} loader_state_t;
endpackage

// File: rtl/counter_bound_loader.sv
// counter_bound_loader: shadows bound pairs from a valid/ready port and commits them at the counter's wrap point.
// Define COUNTER_BOUND_CHECK_EN to reject pairs with lower > upper and raise the sticky cfg_err flag.
module counter_bound_loader
    import counter_pkg::*;
#(
    parameter int                    DATA_WIDTH          = CNT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_LOWER_BOUND = DATA_WIDTH'(CNT_DEFAULT_LOWER),
    parameter logic [DATA_WIDTH-1:0] DEFAULT_UPPER_BOUND = DATA_WIDTH'(CNT_DEFAULT_UPPER)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DATA_WIDTH-1:0] cfg_lower,
    input  logic [DATA_WIDTH-1:0] cfg_upper,
    input  logic [DATA_WIDTH-1:0] cnt_value,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] lower_bound,
    output logic [DATA_WIDTH-1:0] upper_bound,
    output logic                  pending,
    output logic                  commit_pulse,
    output logic                  cfg_err
);
    loader_state_t         r_state, w_next;
    logic [DATA_WIDTH-1:0] r_sh_lower, r_sh_upper, r_lower, r_upper;
    logic                  r_commit_pulse, r_err;
    logic                  w_fire, w_bad, w_commit, w_accept;
    assign w_fire   = cfg_valid && (r_state == IDLE);
`ifdef COUNTER_BOUND_CHECK_EN
    assign w_bad    = cfg_lower > cfg_upper;
`else
    logic w_unused;
    assign w_unused = clear_err;
    assign w_bad    = 1'b0;
`endif
    assign w_accept = w_fire && !w_bad;
    // wrap point: counter is at its top or has been pushed outside the active range
    assign w_commit = (r_state == PENDING) &&
                      (cnt_value == r_upper || cnt_value < r_lower || cnt_value > r_upper);
    always_comb begin
        w_next = r_state;
        if (w_accept) w_next = PENDING;
        else if (w_commit) w_next = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_sh_lower     <= '0;
            r_sh_upper     <= '0;
            r_lower        <= DEFAULT_LOWER_BOUND;
            r_upper        <= DEFAULT_UPPER_BOUND;
            r_commit_pulse <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_commit_pulse <= w_commit;
            if (w_accept) begin
                r_sh_lower <= cfg_lower;
                r_sh_upper <= cfg_upper;
            end
            if (w_commit) begin
                r_lower <= r_sh_lower;
                r_upper <= r_sh_upper;
            end
`ifdef COUNTER_BOUND_CHECK_EN
            // set wins over a simultaneous clear
            r_err <= (w_fire && w_bad) || (r_err && !clear_err);
`else
            r_err <= 1'b0;
`endif
        end
    end
    assign cfg_ready    = (r_state == IDLE);
    assign pending      = (r_state == PENDING);
    assign lower_bound  = r_lower;
    assign upper_bound  = r_upper;
    assign commit_pulse = r_commit_pulse;
    assign cfg_err      = r_err;
endmodule

// File: tb/tb_counter_bound_loader.sv
// tb_counter_bound_loader: directed checks of handshake, wrap-point commit, rejection, async reset and counter interaction.
module tb_counter_bound_loader;
    import counter_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_lower = '0;
    logic [31:0] cfg_upper = '0;
    logic [31:0] cnt_value;
    logic [31:0] tb_cnt = '0;
    logic [31:0] r_cnt;
    logic        use_cnt = 1'b0;
    logic        clear_err = 1'b0;
    logic [31:0] lower_bound, upper_bound;
    logic        pending, commit_pulse, cfg_err;
    int          n_cmp = 0;
    int          n_fail = 0;

    counter_bound_loader dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_lower(cfg_lower), .cfg_upper(cfg_upper), .cnt_value(cnt_value),
        .clear_err(clear_err), .lower_bound(lower_bound), .upper_bound(upper_bound),
        .pending(pending), .commit_pulse(commit_pulse), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // behavioural bounded counter closing the loop for the interaction test
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= 32'(CNT_DEFAULT_LOWER);
        else if (r_cnt == upper_bound || r_cnt < lower_bound || r_cnt > upper_bound) r_cnt <= lower_bound;
        else r_cnt <= r_cnt + 32'd1;
    end
    assign cnt_value = use_cnt ? r_cnt : tb_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        clear_err = 1'b0;
        #3;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (4) tick();
        n_cmp++; if (lower_bound !== 32'd0) begin n_fail++; $display("FAIL reset_lower got %0d want 0", lower_bound); end
        n_cmp++; if (upper_bound !== 32'd255) begin n_fail++; $display("FAIL reset_upper got %0d want 255", upper_bound); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
        n_cmp++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", pending); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", cfg_err); end
        n_cmp++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b want 0", commit_pulse); end
    endtask

    task automatic test_commit();
        tb_cnt = 32'd100;
        cfg_lower = 32'd10; cfg_upper = 32'd20; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_cmp++; if (pending !== 1'b1) begin n_fail++; $display("FAIL commit_pending got %b want 1", pending); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL commit_ready_busy got %b want 0", cfg_ready); end
        n_cmp++; if (lower_bound !== 32'd0 || upper_bound !== 32'd255) begin n_fail++; $display("FAIL commit_early got (%0d,%0d) want (0,255)", lower_bound, upper_bound); end
        cfg_lower = 32'd99; cfg_upper = 32'd99; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_cmp++; if (pending !== 1'b1 || lower_bound !== 32'd0) begin n_fail++; $display("FAIL commit_hold got pending=%b lower=%0d want 1,0", pending, lower_bound); end
        tb_cnt = 32'd255;
        tick();
        n_cmp++; if (lower_bound !== 32'd10 || upper_bound !== 32'd20) begin n_fail++; $display("FAIL commit_bounds got (%0d,%0d) want (10,20)", lower_bound, upper_bound); end
        n_cmp++; if (commit_pulse !== 1'b1) begin n_fail++; $display("FAIL commit_pulse got %b want 1", commit_pulse); end
        n_cmp++; if (cfg_ready !== 1'b1 || pending !== 1'b0) begin n_fail++; $display("FAIL commit_idle got ready=%b pending=%b want 1,0", cfg_ready, pending); end
        tick();
        n_cmp++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL commit_pulse_width got %b want 0", commit_pulse); end
    endtask

    task automatic test_reject();
        tb_cnt = 32'd15;
        cfg_lower = 32'd30; cfg_upper = 32'd5; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
`ifdef COUNTER_BOUND_CHECK_EN
        n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL reject_err got %b want 1", cfg_err); end
        n_cmp++; if (pending !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reject_idle got pending=%b ready=%b want 0,1", pending, cfg_ready); end
        n_cmp++; if (lower_bound !== 32'd10 || upper_bound !== 32'd20) begin n_fail++; $display("FAIL reject_bounds got (%0d,%0d) want (10,20)", lower_bound, upper_bound); end
        cfg_lower = 32'd40; cfg_upper = 32'd1; cfg_valid = 1'b1; clear_err = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL reject_set_wins got %b want 1", cfg_err); end
        tick();
        clear_err = 1'b0;
        n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reject_clear got %b want 0", cfg_err); end
        cfg_lower = 32'd12; cfg_upper = 32'd12; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_cmp++; if (pending !== 1'b1 || cfg_err !== 1'b0) begin n_fail++; $display("FAIL reject_equal_ok got pending=%b err=%b want 1,0", pending, cfg_err); end
`else
        n_cmp++; if (pending !== 1'b1 || cfg_err !== 1'b0) begin n_fail++; $display("FAIL nocheck_accept got pending=%b err=%b want 1,0", pending, cfg_err); end
        tb_cnt = 32'd20;
        tick();
        n_cmp++; if (lower_bound !== 32'd30 || upper_bound !== 32'd5) begin n_fail++; $display("FAIL nocheck_bounds got (%0d,%0d) want (30,5)", lower_bound, upper_bound); end
`endif
    endtask

    task automatic test_out_of_range();
        do_reset();
        tb_cnt = 32'd100;
        cfg_lower = 32'd10; cfg_upper = 32'd20; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tb_cnt = 32'd300;
        tick();
        n_cmp++; if (lower_bound !== 32'd10 || upper_bound !== 32'd20 || commit_pulse !== 1'b1) begin n_fail++; $display("FAIL oor_above got (%0d,%0d) pulse=%b want (10,20) 1", lower_bound, upper_bound, commit_pulse); end
        tb_cnt = 32'd5;
        cfg_lower = 32'd50; cfg_upper = 32'd60; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_cmp++; if (pending !== 1'b1 || commit_pulse !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got pending=%b pulse=%b want 1,0", pending, commit_pulse); end
        tick();
        n_cmp++; if (lower_bound !== 32'd50 || upper_bound !== 32'd60 || pending !== 1'b0) begin n_fail++; $display("FAIL oor_below got (%0d,%0d) pending=%b want (50,60) 0", lower_bound, upper_bound, pending); end
    endtask

    task automatic test_async_reset();
        do_reset();
        tb_cnt = 32'd100;
        cfg_lower = 32'd7; cfg_upper = 32'd9; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tb_cnt = 32'd300;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (pending !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL arst_state got pending=%b ready=%b want 0,1", pending, cfg_ready); end
        n_cmp++; if (lower_bound !== 32'd0 || upper_bound !== 32'd255) begin n_fail++; $display("FAIL arst_bounds got (%0d,%0d) want (0,255)", lower_bound, upper_bound); end
        #3 rst_n = 1'b1;
        repeat (3) tick();
        n_cmp++; if (lower_bound !== 32'd0 || upper_bound !== 32'd255 || commit_pulse !== 1'b0) begin n_fail++; $display("FAIL arst_discard got (%0d,%0d) pulse=%b want (0,255) 0", lower_bound, upper_bound, commit_pulse); end
    endtask

    task automatic test_counter();
        logic [31:0] exp_seq [5];
        int          budget;
        exp_seq = '{32'd0, 32'd5, 32'd6, 32'd7, 32'd5};
        do_reset();
        use_cnt = 1'b1;
        tick();
        cfg_lower = 32'd5; cfg_upper = 32'd7; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        budget = 0;
        while (r_cnt !== 32'd255 && budget < 400) begin tick(); budget++; end
        n_cmp++; if (r_cnt !== 32'd255) begin n_fail++; $display("FAIL cnt_reach_top got %0d want 255", r_cnt); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (r_cnt !== exp_seq[i]) begin n_fail++; $display("FAIL cnt_seq[%0d] got %0d want %0d", i, r_cnt, exp_seq[i]); end
        end
        use_cnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_commit();
        test_reject();
        test_out_of_range();
        test_async_reset();
        test_counter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
